// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the SimpleALU multiplier path.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_16bit_if.sv
// Operand-in / product-out handshake bundle for the shift-and-add multiplier.
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds valid and data stable
// until that edge, and the receiver may drive ready independently of valid.
interface shift_add_mult_16bit_if;

  logic                         in_valid;
  logic                         in_ready;
  logic [alu_pkg::WIDTH-1:0]    in_a;
  logic [alu_pkg::WIDTH-1:0]    in_b;
  logic                         out_valid;
  logic                         out_ready;
  logic [2*alu_pkg::WIDTH-1:0]  out_prod;

  // Issue logic / writeback side
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  // Multiplier side
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );

endinterface

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing the sum
// for carry-in 0 and 1, with the block carry choosing the result.
module carry_select_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_blk
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;

    assign sum_c0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
    assign sum_c1 = sum_c0 + 5'd1;
    assign sum[4*i +: 4] = carry[i] ? sum_c1[3:0] : sum_c0[3:0];
    assign carry[i+1]    = carry[i] ? sum_c1[4]   : sum_c0[4];
  end

  assign cout = carry[4];

endmodule

// File: rtl/mult_shift_reg.sv
// Product shift register {acc_hi, lo}: loads the multiplier into lo with a
// cleared accumulator, then each shift step takes the adder's 17-bit result
// into the top and shifts the consumed multiplier bit out of the bottom.
module mult_shift_reg
  import alu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WIDTH-1:0]     load_lo,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic [2*WIDTH-1:0]   prod
);

  // Load takes priority; shift only happens while the top is BUSY
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod <= '0;
    end else if (load) begin
      prod <= {{WIDTH{1'b0}}, load_lo};
    end else if (shift) begin
      prod <= {cout, sum, prod[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_add_mult_16bit.sv
// Sequential unsigned 16x16 multiplier. One shift-and-add step per BUSY
// cycle through an external adder; fixed 16-cycle iteration, product held
// in DONE until the consumer takes it.
module shift_add_mult_16bit
  import alu_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  shift_add_mult_16bit_if.slave   bus,
  output logic [WIDTH-1:0]        adder_in1,
  output logic [WIDTH-1:0]        adder_in2,
  output logic                    adder_cin,
  input  logic [WIDTH-1:0]        adder_sum,
  input  logic                    adder_cout,
  output state_t                  dbg_state
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    mcand;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [2*WIDTH-1:0]  prod;
  logic                accept;
  logic                shift;

  assign accept = (state == IDLE) && bus.in_valid && in_ready_q;
  assign shift  = (state == BUSY);

  // Control FSM: iteration counter, multiplicand capture, registered handshakes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BUSY;
            mcand      <= bus.in_a;
            cnt        <= '0;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept is at least one cycle later
          if (out_valid_q && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  mult_shift_reg u_shift_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .shift   (shift),
    .load_lo (bus.in_b),
    .sum     (adder_sum),
    .cout    (adder_cout),
    .prod    (prod)
  );

  // Adder operands come straight from registers, so they are never X
  assign adder_in1 = prod[2*WIDTH-1:WIDTH];
  assign adder_in2 = prod[0] ? mcand : '0;
  assign adder_cin = 1'b0;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = prod;
  assign dbg_state     = state;

endmodule

// File: tb/tb_shift_add_mult_16bit.sv
// Directed and randomized bench for shift_add_mult_16bit wired to the
// carry-select adder; expected products come from plain multiplication.
module tb_shift_add_mult_16bit;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT and adder ----------------
  shift_add_mult_16bit_if bus ();

  logic [15:0] adder_in1;
  logic [15:0] adder_in2;
  logic        adder_cin;
  logic [15:0] adder_sum;
  logic        adder_cout;
  state_t      dbg_state;

  shift_add_mult_16bit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .adder_in1  (adder_in1),
    .adder_in2  (adder_in2),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .dbg_state  (dbg_state)
  );

  carry_select_adder_16bit u_adder (
    .a    (adder_in1),
    .b    (adder_in2),
    .cin  (adder_cin),
    .sum  (adder_sum),
    .cout (adder_cout)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks;
  int errors;

  function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    return {16'd0, a} * {16'd0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
      $error("%s observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  // ---------------- driver tasks ----------------
  // Present one operand pair; returns just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int t;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) timeout_fail("send_ready");
    @(posedge clock);
    exp_q.push_back(ref_mult(a, b));
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count rising edges from the accept until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end while (!bus.out_valid && lat < 200);
    if (!bus.out_valid) timeout_fail("wait_done");
  endtask

  // Take the product currently offered and compare with the oldest expectation.
  task automatic take(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      timeout_fail("take_empty_queue");
      e = 32'hxxxxxxxx;
    end else begin
      e = exp_q.pop_front();
    end
    check(tag, bus.out_prod, e);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic [31:0] held;
  int          sent;
  int          recv;
  int          cyc;
  bit          acc_pending;

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    check("reset_in_ready",  32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_prod",  bus.out_prod, 32'd0);
    check("reset_state",     32'(dbg_state), 32'(IDLE));
    check("adder_cin_zero",  32'(adder_cin), 32'd0);

    // 3 x 5 with exact latency
    send(16'h0003, 16'h0005);
    wait_done(lat);
    check("lat_3x5", 32'(lat), 32'd16);
    take("prod_3x5");

    // All ones: carry into acc_hi every step
    send(16'hFFFF, 16'hFFFF);
    wait_done(lat);
    check("lat_ffff", 32'(lat), 32'd16);
    check("prod_ffff_const", bus.out_prod, 32'hFFFE0001);
    take("prod_ffff");

    // Zero operands keep the full latency
    send(16'h1234, 16'h0000);
    wait_done(lat);
    check("lat_zero_b", 32'(lat), 32'd16);
    take("prod_zero_b");
    send(16'h0000, 16'hABCD);
    wait_done(lat);
    check("lat_zero_a", 32'(lat), 32'd16);
    take("prod_zero_a");

    // Back-pressure in DONE with ignored in_valid pulses
    send(16'hBEEF, 16'h1357);
    wait_done(lat);
    held = ref_mult(16'hBEEF, 16'h1357);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_a     = 16'($urandom);
      bus.in_b     = 16'($urandom);
      @(negedge clock);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_prod",  bus.out_prod, held);
      check("hold_in_ready",  32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    take("prod_held");
    @(negedge clock);
    check("after_hold_in_ready",  32'(bus.in_ready), 32'd1);
    check("after_hold_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_hold_retain",    bus.out_prod, held);
    @(negedge clock);
    check("no_stray_accept", 32'(dbg_state), 32'(IDLE));

    // Reset in the middle of BUSY aborts the operation
    send(16'h7A5C, 16'h39E1);
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_state",     32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("abort_in_ready",  32'(bus.in_ready), 32'd1);
    check("abort_out_valid2", 32'(bus.out_valid), 32'd0);
    check("abort_out_prod",  bus.out_prod, 32'd0);
    send(16'h0100, 16'h0100);
    wait_done(lat);
    check("lat_after_abort", 32'(lat), 32'd16);
    check("prod_after_abort_const", bus.out_prod, 32'h00010000);
    take("prod_after_abort");

    // 1000 random back-to-back ops with random out_ready
    sent = 0;
    recv = 0;
    cyc  = 0;
    acc_pending = 1'b1;
    while (recv < 1000 && cyc < 40000) begin
      @(negedge clock);
      cyc++;
      if (acc_pending) begin
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_valid = (sent < 1000);
        acc_pending  = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("rand_unexpected_product");
        end else begin
          check("rand_prod", bus.out_prod, exp_q.pop_front());
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mult(bus.in_a, bus.in_b));
        sent++;
        acc_pending = 1'b1;
      end
    end
    @(negedge clock);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (recv < 1000) timeout_fail("rand_cycle_budget");
    check("rand_sent",  32'(sent), 32'd1000);
    check("rand_recv",  32'(recv), 32'd1000);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clock);
    check("rand_no_extra_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
